// File: rtl/vector_sequencer.sv
// vector_sequencer: walks one of N_LISTS display lists held in a vector memory,
// tracks the pen position and hands start/end coordinate pairs to the line
// drawer over a go/busy handshake. A pass is bounded by MAX_VECTORS entries.
module vector_sequencer #(
  parameter int  OUT_WIDTH   = 8,
  parameter int  ADR_WIDTH   = 8,
  parameter int  N_LISTS     = 4,
  parameter int  RD_LAT      = 1,
  parameter int  MAX_VECTORS = 255,
  localparam int SEL_W       = (N_LISTS > 1) ? $clog2(N_LISTS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable_i,
  input  logic                         frame_start_i,
  input  logic [SEL_W-1:0]             list_sel_i,
  input  logic [N_LISTS*ADR_WIDTH-1:0] list_base_i,
  input  logic                         dot_on_move_i,
  output logic [ADR_WIDTH-1:0]         adr_o,
  output logic                         rd_en_o,
  input  logic [OUT_WIDTH-1:0]         x_i,
  input  logic [OUT_WIDTH-1:0]         y_i,
  input  logic                         line_i,
  input  logic                         pos_i,
  input  logic                         busy_i,
  output logic                         go_o,
  output logic [OUT_WIDTH-1:0]         stax_o,
  output logic [OUT_WIDTH-1:0]         endx_o,
  output logic [OUT_WIDTH-1:0]         stay_o,
  output logic [OUT_WIDTH-1:0]         endy_o,
  output logic                         frame_done_o,
  output logic                         overflow_err_o,
  output logic [ADR_WIDTH-1:0]         vec_count_o,
  output logic [2:0]                   state_debug_o
);

  localparam int LAT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam int ENT_W = (MAX_VECTORS > 0) ? $clog2(MAX_VECTORS + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_SEND     = 3'd3,
    S_ARM      = 3'd4,
    S_WAITBUSY = 3'd5,
    S_NEXT     = 3'd6,
    S_DONE     = 3'd7
  } state_e;

  state_e                state_q, state_d;
  logic [ADR_WIDTH-1:0]  adr_q, adr_d;
  logic [LAT_W-1:0]      latCnt_q, latCnt_d;
  logic [ENT_W-1:0]      entryCnt_q, entryCnt_d;
  logic [OUT_WIDTH-1:0]  penX_q, penX_d, penY_q, penY_d;
  logic [OUT_WIDTH-1:0]  staX_q, staX_d, staY_q, staY_d;
  logic [OUT_WIDTH-1:0]  endX_q, endX_d, endY_q, endY_d;
  logic                  overflow_q, overflow_d;
  logic [ADR_WIDTH-1:0]  vecCount_q, vecCount_d;
  logic [ADR_WIDTH-1:0]  baseSel;

  // Pick the selected list's base address; an out-of-range index falls back to zero.
  always_comb begin
    baseSel = '0;
    for (int i = 0; i < N_LISTS; i++) begin
      if (list_sel_i == SEL_W'(i)) begin
        baseSel = list_base_i[i*ADR_WIDTH +: ADR_WIDTH];
      end
    end
  end

  // Next-state logic: list walk, pen tracking and vector generation.
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    latCnt_d   = latCnt_q;
    entryCnt_d = entryCnt_q;
    penX_d     = penX_q;
    penY_d     = penY_q;
    staX_d     = staX_q;
    staY_d     = staY_q;
    endX_d     = endX_q;
    endY_d     = endY_q;
    overflow_d = overflow_q;
    vecCount_d = vecCount_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start_i && enable_i) begin
          adr_d      = baseSel;
          latCnt_d   = '0;
          entryCnt_d = '0;
          penX_d     = '0;
          penY_d     = '0;
          overflow_d = 1'b0;
          vecCount_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (latCnt_q == LAT_W'(RD_LAT)) begin
          latCnt_d = '0;
          state_d  = S_DECODE;
        end else begin
          latCnt_d = latCnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (pos_i && line_i) begin
          state_d = S_DONE;
        end else if (entryCnt_q == ENT_W'(MAX_VECTORS)) begin
          overflow_d = 1'b1;
          state_d    = S_DONE;
        end else if (pos_i) begin
          penX_d = x_i;
          penY_d = y_i;
          if (dot_on_move_i) begin
            staX_d  = x_i;
            staY_d  = y_i;
            endX_d  = x_i;
            endY_d  = y_i;
            state_d = S_SEND;
          end else begin
            state_d = S_NEXT;
          end
        end else if (line_i) begin
          staX_d  = penX_q;
          staY_d  = penY_q;
          endX_d  = x_i;
          endY_d  = y_i;
          penX_d  = x_i;
          penY_d  = y_i;
          state_d = S_SEND;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_SEND: begin
        if (vecCount_q != '1) begin
          vecCount_d = vecCount_q + 1'b1;
        end
        state_d = S_ARM;
      end
      S_ARM: begin
        state_d = S_WAITBUSY;
      end
      S_WAITBUSY: begin
        if (!busy_i) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        adr_d      = adr_q + 1'b1;
        entryCnt_d = entryCnt_q + 1'b1;
        state_d    = S_FETCH;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops everything without telling the drawer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      adr_q      <= '0;
      latCnt_q   <= '0;
      entryCnt_q <= '0;
      penX_q     <= '0;
      penY_q     <= '0;
      staX_q     <= '0;
      staY_q     <= '0;
      endX_q     <= '0;
      endY_q     <= '0;
      overflow_q <= 1'b0;
      vecCount_q <= '0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      latCnt_q   <= latCnt_d;
      entryCnt_q <= entryCnt_d;
      penX_q     <= penX_d;
      penY_q     <= penY_d;
      staX_q     <= staX_d;
      staY_q     <= staY_d;
      endX_q     <= endX_d;
      endY_q     <= endY_d;
      overflow_q <= overflow_d;
      vecCount_q <= vecCount_d;
    end
  end

  assign rd_en_o        = (state_q == S_FETCH) && (latCnt_q == '0);
  assign go_o           = (state_q == S_SEND);
  assign frame_done_o   = (state_q == S_DONE);
  assign adr_o          = adr_q;
  assign stax_o         = staX_q;
  assign stay_o         = staY_q;
  assign endx_o         = endX_q;
  assign endy_o         = endY_q;
  assign overflow_err_o = overflow_q;
  assign vec_count_o    = vecCount_q;
  assign state_debug_o  = state_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// tb_vector_sequencer: drives vector_sequencer with a latency-accurate list memory
// and a simple line-drawer model, and checks directed and random display lists.
`timescale 1ns/1ps
module tb_vector_sequencer;

  localparam int OW = 8;
  localparam int AW = 8;
  localparam int NL = 4;
  localparam int RL = 3;
  localparam int MV = 4;

  typedef struct packed {
    logic       line;
    logic       pos;
    logic [7:0] x;
    logic [7:0] y;
  } ent_t;

  typedef struct packed {
    logic [7:0] sx;
    logic [7:0] sy;
    logic [7:0] ex;
    logic [7:0] ey;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic           frameStart = 1'b0;
  logic [1:0]     listSel = 2'd0;
  logic [NL*AW-1:0] listBase = '0;
  logic           dotOnMove = 1'b0;
  logic [AW-1:0]  adr;
  logic           rdEn;
  logic [OW-1:0]  memX = '0, memY = '0;
  logic           memLine = 1'b0, memPos = 1'b0;
  logic           busy;
  logic           go;
  logic [OW-1:0]  stax, endx, stay, endy;
  logic           frameDone, overflowErr;
  logic [AW-1:0]  vecCount;
  logic [2:0]     stateDebug;

  int checks = 0;
  int errors = 0;

  vector_sequencer #(
    .OUT_WIDTH(OW), .ADR_WIDTH(AW), .N_LISTS(NL), .RD_LAT(RL), .MAX_VECTORS(MV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .frame_start_i(frameStart),
    .list_sel_i(listSel), .list_base_i(listBase), .dot_on_move_i(dotOnMove),
    .adr_o(adr), .rd_en_o(rdEn), .x_i(memX), .y_i(memY), .line_i(memLine),
    .pos_i(memPos), .busy_i(busy), .go_o(go), .stax_o(stax), .endx_o(endx),
    .stay_o(stay), .endy_o(endy), .frame_done_o(frameDone),
    .overflow_err_o(overflowErr), .vec_count_o(vecCount), .state_debug_o(stateDebug)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time strobes relative to each other.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // List memory: junk right after a read, valid data RL cycles after rd_en, then held.
  ent_t mem [256];
  logic p0 = 1'b0, p1 = 1'b0;
  logic [7:0] a0 = '0, a1 = '0;
  always @(posedge clk) begin
    p0 <= rdEn;
    a0 <= adr;
    p1 <= p0;
    a1 <= a0;
    if (rdEn) begin
      memX    <= 8'($urandom);
      memY    <= 8'($urandom);
      memLine <= 1'($urandom);
      memPos  <= 1'($urandom);
    end
    if (p1) begin
      memX    <= mem[a1].x;
      memY    <= mem[a1].y;
      memLine <= mem[a1].line;
      memPos  <= mem[a1].pos;
    end
  end

  // Line drawer: busy rises the cycle after go and stays high busyLen cycles.
  int busyLen = 3;
  int busyCnt = 0;
  always @(posedge clk) begin
    if (go) busyCnt <= busyLen;
    else if (busyCnt > 0) busyCnt <= busyCnt - 1;
  end
  assign busy = (busyCnt != 0);

  // Monitor: logs strobes and flags protocol violations on the falling edge.
  vec_t goQ[$];
  int   goCyc[$];
  int   rdCyc[$];
  int   doneCount = 0;
  int   busyGoErr = 0;
  int   stableErr = 0;
  vec_t lastGo = '0;
  logic holdActive = 1'b0;
  always @(negedge clk) begin
    if (rdEn) rdCyc.push_back(cyc);
    if (frameDone) doneCount <= doneCount + 1;
    if (!rst_n) begin
      holdActive <= 1'b0;
    end else if (go) begin
      goQ.push_back({stax, stay, endx, endy});
      goCyc.push_back(cyc);
      lastGo     <= {stax, stay, endx, endy};
      holdActive <= 1'b1;
      if (busy) busyGoErr <= busyGoErr + 1;
    end else if (!busy) begin
      holdActive <= 1'b0;
    end else if (holdActive && ({stax, stay, endx, endy} != lastGo)) begin
      stableErr <= stableErr + 1;
    end
  end

  // Watchdog against a hung sequencer.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model results for one pass.
  vec_t       expQ[$];
  int         expVc;
  int         expReads;
  bit         expOvf;
  logic [7:0] expAdr;

  task automatic modelFrame(input logic [7:0] base, input bit dotv);
    logic [7:0] px, py, a;
    ent_t e;
    int i;
    expQ.delete();
    px = '0; py = '0; expOvf = 1'b0; expReads = 0; i = 0;
    while (1) begin
      a = base + 8'(i);
      e = mem[a];
      expReads++;
      if (e.line && e.pos) break;
      if (i == MV) begin
        expOvf = 1'b1;
        break;
      end
      if (e.pos) begin
        px = e.x; py = e.y;
        if (dotv) expQ.push_back({e.x, e.y, e.x, e.y});
      end else if (e.line) begin
        expQ.push_back({px, py, e.x, e.y});
        px = e.x; py = e.y;
      end
      i++;
    end
    expAdr = base + 8'(i);
    expVc  = expQ.size();
  endtask

  task automatic setEntry(input logic [7:0] a, input bit ln, input bit ps, input logic [7:0] ex, input logic [7:0] ey);
    mem[a].line = ln;
    mem[a].pos  = ps;
    mem[a].x    = ex;
    mem[a].y    = ey;
  endtask

  // Runs one frame; optional mid-frame frame_start pulse and enable drop.
  task automatic runFrame(input int sel, input bit dotv, input int blen, input int midPulseAt,
                          input bit dropEn, output bit tout, output int startCyc, output int doneDelta);
    int d0;
    int n;
    busyLen = blen;
    listSel = 2'(sel);
    dotOnMove = dotv;
    enable = 1'b1;
    goQ.delete(); goCyc.delete(); rdCyc.delete();
    @(negedge clk); #1;
    d0 = doneCount;
    startCyc = cyc;
    frameStart = 1'b1;
    @(negedge clk); #1;
    frameStart = 1'b0;
    tout = 1'b1;
    n = 0;
    while (n < 3000) begin
      @(negedge clk); #1;
      n++;
      if (dropEn && n == 2) enable = 1'b0;
      if (n == midPulseAt) begin
        frameStart = 1'b1;
        listSel = 2'(sel + 1);
      end else begin
        frameStart = 1'b0;
      end
      if (doneCount != d0) begin
        tout = 1'b0;
        break;
      end
    end
    frameStart = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    doneDelta = doneCount - d0;
  endtask

  task automatic test_reset();
    checks++; if (adr !== 8'h00) begin errors++; $display("[TB] FAIL reset_adr: got %h expected 00", adr); end
    checks++; if ({rdEn, go, frameDone, overflowErr} !== 4'b0) begin errors++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {rdEn, go, frameDone, overflowErr}); end
    checks++; if ({stax, stay, endx, endy} !== 32'h0) begin errors++; $display("[TB] FAIL reset_coords: got %h expected 00000000", {stax, stay, endx, endy}); end
    checks++; if (vecCount !== 8'h00) begin errors++; $display("[TB] FAIL reset_vec_count: got %0d expected 0", vecCount); end
    checks++; if (stateDebug !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", stateDebug); end
  endtask

  task automatic test_basic_list();
    bit tout; int sc, dd; vec_t got; vec_t ev[2];
    listBase[1*AW +: AW] = 8'h10;
    setEntry(8'h10, 0, 1, 8'd10, 8'd20);
    setEntry(8'h11, 1, 0, 8'd30, 8'd40);
    setEntry(8'h12, 1, 0, 8'd50, 8'd60);
    setEntry(8'h13, 1, 1, 8'd0, 8'd0);
    ev[0] = {8'd10, 8'd20, 8'd30, 8'd40};
    ev[1] = {8'd30, 8'd40, 8'd50, 8'd60};
    runFrame(1, 0, 3, 0, 0, tout, sc, dd);
    checks++; if (tout !== 1'b0) begin errors++; $display("[TB] FAIL basic_timeout: got timeout expected frame_done"); end
    checks++; if (goQ.size() != 2) begin errors++; $display("[TB] FAIL basic_go_count: got %0d expected 2", goQ.size()); end
    for (int i = 0; i < 2; i++) begin
      got = '0;
      if (i < goQ.size()) got = goQ[i];
      checks++; if (got !== ev[i]) begin errors++; $display("[TB] FAIL basic_vec%0d: got %h expected %h", i, got, ev[i]); end
    end
    checks++; if (dd != 1) begin errors++; $display("[TB] FAIL basic_done_pulses: got %0d expected 1", dd); end
    checks++; if (vecCount !== 8'd2) begin errors++; $display("[TB] FAIL basic_vec_count: got %0d expected 2", vecCount); end
    checks++; if (adr !== 8'h13) begin errors++; $display("[TB] FAIL basic_final_adr: got %h expected 13", adr); end
    checks++; if (overflowErr !== 1'b0) begin errors++; $display("[TB] FAIL basic_overflow: got %b expected 0", overflowErr); end
    checks++; if (rdCyc.size() != 4) begin errors++; $display("[TB] FAIL basic_reads: got %0d expected 4", rdCyc.size()); end
  endtask

  task automatic test_dot_on_move();
    bit tout; int sc, dd; vec_t got; vec_t ev[3];
    listBase[2*AW +: AW] = 8'h80;
    setEntry(8'h80, 1, 0, 8'd99, 8'd99);
    setEntry(8'h81, 1, 1, 8'd0, 8'd0);
    ev[0] = {8'd10, 8'd20, 8'd10, 8'd20};
    ev[1] = {8'd10, 8'd20, 8'd30, 8'd40};
    ev[2] = {8'd30, 8'd40, 8'd50, 8'd60};
    runFrame(1, 1, 2, 8, 0, tout, sc, dd);
    checks++; if (tout !== 1'b0) begin errors++; $display("[TB] FAIL dot_timeout: got timeout expected frame_done"); end
    checks++; if (goQ.size() != 3) begin errors++; $display("[TB] FAIL dot_go_count: got %0d expected 3", goQ.size()); end
    for (int i = 0; i < 3; i++) begin
      got = '0;
      if (i < goQ.size()) got = goQ[i];
      checks++; if (got !== ev[i]) begin errors++; $display("[TB] FAIL dot_vec%0d: got %h expected %h", i, got, ev[i]); end
    end
    checks++; if (vecCount !== 8'd3) begin errors++; $display("[TB] FAIL dot_vec_count: got %0d expected 3", vecCount); end
    checks++; if (rdCyc.size() != 4 || dd != 1) begin errors++; $display("[TB] FAIL dot_ignore_restart: got reads=%0d done=%0d expected reads=4 done=1", rdCyc.size(), dd); end
  endtask

  task automatic test_line_first();
    bit tout; int sc, dd; vec_t got;
    listBase[0*AW +: AW] = 8'h00;
    setEntry(8'h00, 1, 0, 8'd5, 8'd5);
    setEntry(8'h01, 1, 1, 8'd0, 8'd0);
    runFrame(0, 0, 1, 0, 1, tout, sc, dd);
    got = '0;
    if (goQ.size() > 0) got = goQ[0];
    checks++; if (tout !== 1'b0 || goQ.size() != 1) begin errors++; $display("[TB] FAIL linefirst_go_count: got %0d timeout=%b expected 1 timeout=0", goQ.size(), tout); end
    checks++; if (got !== {8'd0, 8'd0, 8'd5, 8'd5}) begin errors++; $display("[TB] FAIL linefirst_vec: got %h expected 00000505", got); end
    checks++; if (adr !== 8'h01 || vecCount !== 8'd1) begin errors++; $display("[TB] FAIL linefirst_adr_count: got adr=%h cnt=%0d expected adr=01 cnt=1", adr, vecCount); end
  endtask

  task automatic test_overflow();
    bit tout; int sc, dd;
    listBase[3*AW +: AW] = 8'hFE;
    for (int k = 0; k < 6; k++) setEntry(8'hFE + 8'(k), 1, 0, 8'(k + 1), 8'(k + 1));
    runFrame(3, 0, 2, 0, 0, tout, sc, dd);
    checks++; if (tout !== 1'b0 || dd != 1) begin errors++; $display("[TB] FAIL ovf_done: got done=%0d timeout=%b expected 1 timeout=0", dd, tout); end
    checks++; if (overflowErr !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflowErr); end
    checks++; if (goQ.size() != 4 || vecCount !== 8'd4) begin errors++; $display("[TB] FAIL ovf_vectors: got go=%0d cnt=%0d expected 4", goQ.size(), vecCount); end
    checks++; if (rdCyc.size() != 5 || adr !== 8'h02) begin errors++; $display("[TB] FAIL ovf_walk: got reads=%0d adr=%h expected reads=5 adr=02", rdCyc.size(), adr); end
    checks++; if (goQ.size() == 4 && goQ[3] !== {8'd3, 8'd3, 8'd4, 8'd4}) begin errors++; $display("[TB] FAIL ovf_last_vec: got %h expected 03030404", goQ[3]); end
    repeat (6) @(negedge clk);
    #1;
    checks++; if (overflowErr !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflowErr); end
  endtask

  task automatic test_marker_at_limit();
    bit tout; int sc, dd; vec_t got;
    listBase[2*AW +: AW] = 8'h80;
    setEntry(8'h80, 0, 1, 8'd7, 8'd8);
    setEntry(8'h81, 0, 0, 8'd33, 8'd44);
    setEntry(8'h82, 0, 0, 8'd55, 8'd66);
    setEntry(8'h83, 1, 0, 8'd9, 8'd9);
    setEntry(8'h84, 1, 1, 8'd0, 8'd0);
    runFrame(2, 0, 1, 0, 0, tout, sc, dd);
    got = '0;
    if (goQ.size() > 0) got = goQ[0];
    checks++; if (overflowErr !== 1'b0) begin errors++; $display("[TB] FAIL limit_overflow: got %b expected 0", overflowErr); end
    checks++; if (got !== {8'd7, 8'd8, 8'd9, 8'd9} || goQ.size() != 1) begin errors++; $display("[TB] FAIL limit_vec: got %h n=%0d expected 07080909 n=1", got, goQ.size()); end
    checks++; if (adr !== 8'h84 || rdCyc.size() != 5 || dd != 1) begin errors++; $display("[TB] FAIL limit_walk: got adr=%h reads=%0d done=%0d expected 84 5 1", adr, rdCyc.size(), dd); end
  endtask

  task automatic test_latency();
    bit tout; int sc, dd; int r0, r1, g0, g1;
    listBase[2*AW +: AW] = 8'h40;
    setEntry(8'h40, 1, 0, 8'd1, 8'd2);
    setEntry(8'h41, 1, 0, 8'd3, 8'd4);
    setEntry(8'h42, 1, 1, 8'd0, 8'd0);
    runFrame(2, 0, 10, 0, 0, tout, sc, dd);
    r0 = (rdCyc.size() > 0) ? rdCyc[0] : -1000;
    r1 = (rdCyc.size() > 1) ? rdCyc[1] : -1000;
    g0 = (goCyc.size() > 0) ? goCyc[0] : -1000;
    g1 = (goCyc.size() > 1) ? goCyc[1] : -1000;
    checks++; if (r0 - sc != 1) begin errors++; $display("[TB] FAIL lat_start_to_rd: got %0d expected 1", r0 - sc); end
    checks++; if (g0 - r0 != RL + 2) begin errors++; $display("[TB] FAIL lat_rd_to_go: got %0d expected %0d", g0 - r0, RL + 2); end
    checks++; if (r1 - g0 != 13) begin errors++; $display("[TB] FAIL lat_go_to_next_rd: got %0d expected 13", r1 - g0); end
    checks++; if (g1 - g0 != 13 + RL + 2) begin errors++; $display("[TB] FAIL lat_go_to_go: got %0d expected %0d", g1 - g0, 13 + RL + 2); end
    checks++; if (busyGoErr != 0 || stableErr != 0) begin errors++; $display("[TB] FAIL lat_handshake: got go_while_busy=%0d unstable=%0d expected 0 0", busyGoErr, stableErr); end
  endtask

  task automatic test_random();
    bit tout; int sc, dd; int n, t; bit dotv; int blen, sel; logic [7:0] base, a; vec_t got;
    for (int it = 0; it < 14; it++) begin
      base = 8'($urandom);
      sel  = $urandom_range(0, NL - 1);
      listBase = NL*AW'($urandom);
      listBase[sel*AW +: AW] = base;
      for (int k = 0; k < 8; k++) begin
        a = base + 8'(k);
        t = $urandom_range(0, 2);
        setEntry(a, t == 2, t == 1, 8'($urandom), 8'($urandom));
      end
      n = $urandom_range(0, MV + 1);
      if (n <= MV) setEntry(base + 8'(n), 1, 1, 8'($urandom), 8'($urandom));
      dotv = 1'($urandom_range(0, 1));
      blen = $urandom_range(0, 4);
      modelFrame(base, dotv);
      runFrame(sel, dotv, blen, 0, 0, tout, sc, dd);
      checks++; if (tout !== 1'b0 || dd != 1) begin errors++; $display("[TB] FAIL rand%0d_done: got done=%0d timeout=%b expected 1 0", it, dd, tout); end
      checks++; if (goQ.size() != expVc) begin errors++; $display("[TB] FAIL rand%0d_go_count: got %0d expected %0d", it, goQ.size(), expVc); end
      for (int i = 0; i < expVc; i++) begin
        got = '0;
        if (i < goQ.size()) got = goQ[i];
        checks++; if (got !== expQ[i]) begin errors++; $display("[TB] FAIL rand%0d_vec%0d: got %h expected %h", it, i, got, expQ[i]); end
      end
      checks++; if (vecCount !== 8'(expVc)) begin errors++; $display("[TB] FAIL rand%0d_vec_count: got %0d expected %0d", it, vecCount, expVc); end
      checks++; if (overflowErr !== expOvf) begin errors++; $display("[TB] FAIL rand%0d_overflow: got %b expected %b", it, overflowErr, expOvf); end
      checks++; if (adr !== expAdr || rdCyc.size() != expReads) begin errors++; $display("[TB] FAIL rand%0d_walk: got adr=%h reads=%0d expected adr=%h reads=%0d", it, adr, rdCyc.size(), expAdr, expReads); end
    end
    checks++; if (busyGoErr != 0 || stableErr != 0) begin errors++; $display("[TB] FAIL rand_handshake: got go_while_busy=%0d unstable=%0d expected 0 0", busyGoErr, stableErr); end
  endtask

  task automatic test_reset_mid();
    int n;
    listBase[0*AW +: AW] = 8'h20;
    setEntry(8'h20, 1, 0, 8'd11, 8'd12);
    setEntry(8'h21, 1, 0, 8'd13, 8'd14);
    setEntry(8'h22, 1, 1, 8'd0, 8'd0);
    busyLen = 20;
    listSel = 2'd0;
    dotOnMove = 1'b0;
    enable = 1'b1;
    @(negedge clk); #1;
    frameStart = 1'b1;
    @(negedge clk); #1;
    frameStart = 1'b0;
    n = 0;
    while (stateDebug !== 3'd5 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    checks++; if (stateDebug !== 3'd5) begin errors++; $display("[TB] FAIL rstmid_reach_waitbusy: got state %0d expected 5", stateDebug); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (stateDebug !== 3'd0) begin errors++; $display("[TB] FAIL rstmid_state: got %0d expected 0", stateDebug); end
    checks++; if (adr !== 8'h00 || vecCount !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_adr_count: got adr=%h cnt=%0d expected 00 0", adr, vecCount); end
    checks++; if ({stax, stay, endx, endy} !== 32'h0 || {rdEn, go, frameDone, overflowErr} !== 4'b0) begin errors++; $display("[TB] FAIL rstmid_outputs: got coords=%h strobes=%b expected 0", {stax, stay, endx, endy}, {rdEn, go, frameDone, overflowErr}); end
    @(negedge clk); #1;
    rst_n = 1'b1;
    enable = 1'b0;
    rdCyc.delete();
    @(negedge clk); #1;
    frameStart = 1'b1;
    @(negedge clk); #1;
    frameStart = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (rdCyc.size() != 0 || stateDebug !== 3'd0) begin errors++; $display("[TB] FAIL disabled_start: got reads=%0d state=%0d expected 0 0", rdCyc.size(), stateDebug); end
    enable = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    test_basic_list();
    test_dot_on_move();
    test_line_first();
    test_overflow();
    test_marker_at_limit();
    test_latency();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
- Next-generation display-list walker for the vector display path.
- Fetches {x, y, line, pos} entries from one of N_LISTS display lists in a vector ROM/RAM, tracks the pen position, and issues start/end coordinate pairs to the line drawer over a go/busy handshake.
- Adds over the previous generation:
  - multiple selectable lists with base addresses
  - configurable memory read latency
  - optional dot-on-move
  - frame-start gating
  - runaway-list protection

Parameters:
- OUT_WIDTH, 8: coordinate width.
- ADR_WIDTH, 8: list memory address width.
- N_LISTS, 4: number of selectable display lists (>=1).
- RD_LAT, 1: memory read latency in cycles, adr to valid data (>=1).
- MAX_VECTORS, 255: maximum entries walked per frame before abort.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  sequencer enable, sampled in IDLE only
- frame_start  in  1  pulse; requests one pass over the selected list
- list_sel  in  max(1,$clog2(N_LISTS))  list index, sampled on accepted frame_start
- list_base  in  N_LISTS*ADR_WIDTH  packed base addresses; list i at [i*ADR_WIDTH +: ADR_WIDTH]
- dot_on_move  in  1  1: pos entries also emit a zero-length vector
- adr  out  ADR_WIDTH  memory address
- rd_en  out  1  one-cycle read strobe
- x, y  in  OUT_WIDTH each  entry coordinates, valid RD_LAT cycles after rd_en
- line, pos  in  1 each  entry type; both high = end-of-list marker
- busy  in  1  line drawer busy
- go  out  1  one-cycle draw request
- stax, endx, stay, endy  out  OUT_WIDTH each  vector coordinates, stable from go until busy falls
- frame_done  out  1  one-cycle pulse at end of pass
- overflow_err  out  1  sticky; list exceeded MAX_VECTORS
- vec_count  out  ADR_WIDTH  vectors issued in current/last frame
- state_debug  out  3  encoded current state

Behaviour:
- Reset (async, rst_n=0), all outputs and registers zero: adr, rd_en, go, coordinates, frame_done, overflow_err, vec_count, pen position, entry counter; state = IDLE. Applies mid-operation; the drawer is not notified.
- States:
  - IDLE: waits for frame_start && enable. Then: latch base = list_base[list_sel]; adr = base; pen = (0,0); entry counter = 0; vec_count = 0; clear overflow_err → FETCH. frame_start while not IDLE is ignored.
  - FETCH: rd_en=1 for one cycle, then wait RD_LAT cycles → DECODE.
  - DECODE (one cycle), evaluated in this priority order:
    - pos && line: end marker → DONE.
    - entry counter == MAX_VECTORS: overflow_err=1 → DONE.
    - pos only: pen = (x,y). If dot_on_move: sta = end = (x,y) → SEND. Else → NEXT.
    - line only: sta = pen, end = (x,y), pen = (x,y) → SEND.
    - neither bit set: no-op → NEXT.
  - SEND: go=1 for exactly one cycle; vec_count += 1 (saturating) → ARM.
  - ARM: one cycle, busy ignored (drawer latency) → WAITBUSY.
  - WAITBUSY: stay while busy=1; busy=0 → NEXT.
  - NEXT: adr += 1 (wraps at 2^ADR_WIDTH); entry counter += 1 → FETCH.
  - DONE: frame_done=1 for one cycle → IDLE.
- The end marker is checked before the overflow limit, so a marker at entry MAX_VECTORS is a clean end.
- enable low in IDLE blocks new frames. enable dropping mid-frame does not abort the frame.
- Latency:
  - frame_start to first rd_en: 1 cycle.
  - rd_en to go, line entry: RD_LAT+2 cycles.
- Coordinates are held in registers and change only in DECODE.
- state_debug encoding: IDLE=0, FETCH=1, DECODE=2, SEND=3, ARM=4, WAITBUSY=5, NEXT=6, DONE=7.

Test Plan:
- List 1 at base 0x10 = [pos(10,20), line(30,40), line(50,60), marker], dot_on_move=0, busy high 3 cycles per go → 2 go pulses: (10,20)->(30,40) then (30,40)->(50,60); frame_done once; vec_count=2; adr ends 0x13.
- Same list, dot_on_move=1 → 3 go pulses; first is (10,20)->(10,20); vec_count=3.
- First entry line(5,5), no preceding pos → vector (0,0)->(5,5).
- List without marker, MAX_VECTORS=4 → 4 entries walked; overflow_err=1 (sticky until next frame_start); frame_done pulses.
- RD_LAT=3, busy held 10 cycles → go asserted 5 cycles after rd_en; next rd_en only after busy falls; no second go while busy.
- rst_n pulsed low during WAITBUSY → all outputs 0 immediately, state IDLE; frame_start with enable=0 → no rd_en.
